// File: rtl/ps2_pkg.sv
// Shared byte codes, device-reply list and FSM state types for the PS/2 keyboard receiver.
// Optional parity/stop checking is enabled by defining PS2_KEY_PARITY_EN.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_BRK     = 8'hF0;
    localparam logic [7:0] PS2_PAUSE   = 8'hE1;
    localparam logic [7:0] PS2_PRT_MK  = 8'h12;
    localparam logic [7:0] PS2_PRT_BRK = 8'h7C;

    // Keyboard-to-host replies (BAT ok, ACK, echo, resend, BAT fail, overrun x2).
    localparam int PS2_REPLY_N = 7;
    localparam logic [PS2_REPLY_N-1:0][7:0] PS2_REPLY_CODES =
        {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_START,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_PFX,
        SQ_PRT,
        SQ_PAUSE
    } seq_state_t;

    function automatic logic is_reply(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_REPLY_N; i++) begin
            if (b == PS2_REPLY_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: input sync, clock glitch filter, inactivity timeout, frame FSM.
// With PS2_KEY_PARITY_EN defined, odd parity and the stop bit are checked before a byte is accepted.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 600000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err,
    output logic       timeout,
    output logic       frame_busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          clk_edge;
    logic          clk_fall;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_reach;

    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          start_bit;
`ifdef PS2_KEY_PARITY_EN
    logic          par_bit;
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
            clk_edge  <= 1'b0;
            clk_fall  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_edge  <= 1'b0;
            clk_fall  <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                clk_edge <= 1'b1;
                clk_fall <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Counter saturates at TIMEOUT_CYC so the timeout fires once per quiet period.
    assign tmo_reach = !clk_edge && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= tmo_reach;
            if (clk_edge)
                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT_CYC))
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= FR_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            start_bit <= 1'b1;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
`ifdef PS2_KEY_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (state != FR_IDLE && tmo_reach) begin
                frame_err <= 1'b1;
                state     <= FR_IDLE;
            end else begin
                case (state)
                    FR_IDLE: if (clk_fall) begin
                        start_bit <= data_sync[1];
                        state     <= FR_START;
                    end
                    FR_START: begin
                        bit_cnt <= '0;
                        if (start_bit) begin
                            frame_err <= 1'b1;
                            state     <= FR_IDLE;
                        end else begin
                            state <= FR_DATA;
                        end
                    end
                    FR_DATA: if (clk_fall) begin
                        shreg   <= {data_sync[1], shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= FR_PARITY;
                    end
                    FR_PARITY: if (clk_fall) begin
`ifdef PS2_KEY_PARITY_EN
                        par_bit <= data_sync[1];
`endif
                        state <= FR_STOP;
                    end
                    FR_STOP: if (clk_fall) begin
                        state <= FR_IDLE;
`ifdef PS2_KEY_PARITY_EN
                        if ((^{shreg, par_bit}) && data_sync[1])
                            byte_vld <= 1'b1;
                        else
                            frame_err <= 1'b1;
`else
                        byte_vld <= 1'b1;
`endif
                    end
                    default: state <= FR_IDLE;
                endcase
            end
        end
    end

    assign rx_byte    = shreg;
    assign frame_busy = (state != FR_IDLE);

endmodule

// File: rtl/ps2_key_packer.sv
// Host-side PS/2 keyboard receiver: groups E0/F0/E1 prefixed bytes into one 65-bit ps2_key event.
// Defining PS2_KEY_PARITY_EN also aborts a partial sequence when a frame fails parity/stop checks.
module ps2_key_packer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 600000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [64:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    logic [7:0]  rx_byte;
    logic        byte_vld;
    logic        timeout;
    logic        frame_busy;

    seq_state_t  sq_state;
    seq_state_t  sq_nxt;
    logic [2:0]  byte_cnt;
    logic [55:0] acc;
    logic [63:0] acc_nxt;
    logic        prt_brk;
    logic        complete;
    logic        drop;
    logic        seq_abort;
    logic [3:0]  total;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .rx_byte     (rx_byte),
        .byte_vld    (byte_vld),
        .frame_err   (frame_err),
        .timeout     (timeout),
        .frame_busy  (frame_busy)
    );

`ifdef PS2_KEY_PARITY_EN
    assign seq_abort = timeout | frame_err;
`else
    assign seq_abort = timeout;
`endif

    assign total   = {1'b0, byte_cnt} + 4'd1;
    assign acc_nxt = (sq_state == SQ_IDLE) ? {56'h0, rx_byte} : {acc, rx_byte};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sq_nxt   = sq_state;
        complete = 1'b0;
        drop     = 1'b0;
        case (sq_state)
            SQ_IDLE: begin
                if (is_reply(rx_byte))
                    drop = 1'b1;
                else if (rx_byte == PS2_EXT || rx_byte == PS2_BRK)
                    sq_nxt = SQ_PFX;
                else if (rx_byte == PS2_PAUSE)
                    sq_nxt = SQ_PAUSE;
                else
                    complete = 1'b1;
            end
            SQ_PFX: begin
                if (byte_cnt == 3'd7)
                    complete = 1'b1;
                else if (rx_byte == PS2_PRT_MK && byte_cnt == 3'd1 && acc[7:0] == PS2_EXT)
                    sq_nxt = SQ_PRT;
                else if (rx_byte == PS2_PRT_BRK && byte_cnt == 3'd2 && acc[15:0] == {PS2_EXT, PS2_BRK})
                    sq_nxt = SQ_PRT;
                else if (rx_byte != PS2_EXT && rx_byte != PS2_BRK)
                    complete = 1'b1;
            end
            SQ_PRT:   complete = (total == (prt_brk ? 4'd6 : 4'd4));
            SQ_PAUSE: complete = (byte_cnt == 3'd7);
            default:  complete = 1'b1;
        endcase
    end

    // The event word is written the cycle after the final byte_vld, together with busy falling.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sq_state <= SQ_IDLE;
            byte_cnt <= '0;
            acc      <= '0;
            prt_brk  <= 1'b0;
            ps2_key  <= '0;
        end else if (seq_abort) begin
            sq_state <= SQ_IDLE;
            byte_cnt <= '0;
        end else if (byte_vld && !drop) begin
            acc <= acc_nxt[55:0];
            if (complete) begin
                ps2_key  <= {~ps2_key[64], acc_nxt};
                sq_state <= SQ_IDLE;
                byte_cnt <= '0;
            end else begin
                sq_state <= sq_nxt;
                byte_cnt <= byte_cnt + 1'b1;
                if (sq_state == SQ_PFX && sq_nxt == SQ_PRT)
                    prt_brk <= (rx_byte == PS2_PRT_BRK);
            end
        end
    end

    assign busy = frame_busy | (sq_state != SQ_IDLE);

endmodule

// File: tb/tb_ps2_key_packer.sv
// Directed bench for ps2_key_packer: serial PS/2 frames at 10 us/bit on a 10 MHz clk_sys.
// Parity expectations follow PS2_KEY_PARITY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_ps2_key_packer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [64:0] ps2_key;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int tog_cnt = 0;
    int err_cnt = 0;
    logic prev_tog = 1'b0;

    logic        exp_tog;
    logic [63:0] exp_word;
    int          t0;
    int          e0;
    logic [7:0]  pause_seq [8];

    ps2_key_packer #(
        .FILTER_LEN  (4),
        .TIMEOUT_CYC (3000)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #50 clk_sys = ~clk_sys;

    // Counts strobe toggles and frame_err pulses between directed steps.
    always @(negedge clk_sys) begin
        if (reset) begin
            prev_tog = 1'b0;
        end else if (ps2_key[64] !== prev_tog) begin
            tog_cnt++;
            prev_tog = ps2_key[64];
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample_point();
        @(negedge clk_sys);
        #10;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data_in = fr[i];
            #2500 ps2_clk_in = 1'b0;
            #5000 ps2_clk_in = 1'b1;
            #2500;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(fr, 11);
        ps2_data_in = 1'b1;
        #20000;
    endtask

    initial begin
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        reset       = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        exp_tog     = 1'b0;
        exp_word    = 64'h0;
        repeat (5) @(posedge clk_sys);
        sample_point();
        check("rst_key", ps2_key, 65'h0);
        check("rst_ferr", 65'(frame_err), 65'h0);
        check("rst_busy", 65'(busy), 65'h0);
        reset = 1'b0;
        repeat (20) @(posedge clk_sys);

        // Single make code
        t0 = tog_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b0);
        sample_point();
        exp_tog = ~exp_tog; exp_word = 64'h1C;
        check("1c_key", ps2_key, {exp_tog, exp_word});
        check("1c_toggles", 65'(tog_cnt - t0), 65'd1);
        check("1c_ferr", 65'(err_cnt - e0), 65'd0);
        check("1c_busy", 65'(busy), 65'h0);

        // Break then extended break
        t0 = tog_cnt;
        send_byte(8'hF0, 1'b0);
        sample_point();
        check("f0_busy", 65'(busy), 65'h1);
        check("f0_key_held", ps2_key, {exp_tog, exp_word});
        send_byte(8'h1C, 1'b0);
        sample_point();
        exp_tog = ~exp_tog; exp_word = 64'hF01C;
        check("f01c_key", ps2_key, {exp_tog, exp_word});
        check("f01c_busy", 65'(busy), 65'h0);
        send_byte(8'hE0, 1'b0);
        sample_point();
        check("e0_busy", 65'(busy), 65'h1);
        send_byte(8'hF0, 1'b0);
        sample_point();
        check("e0f0_busy", 65'(busy), 65'h1);
        send_byte(8'h75, 1'b0);
        sample_point();
        exp_tog = ~exp_tog; exp_word = 64'hE0F075;
        check("e0f075_key", ps2_key, {exp_tog, exp_word});
        check("two_seq_toggles", 65'(tog_cnt - t0), 65'd2);

        // PrtScr make: stays open after E0 12
        send_byte(8'hE0, 1'b0);
        send_byte(8'h12, 1'b0);
        sample_point();
        check("prt_e012_busy", 65'(busy), 65'h1);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h7C, 1'b0);
        sample_point();
        exp_tog = ~exp_tog; exp_word = 64'hE012E07C;
        check("prt_make_key", ps2_key, {exp_tog, exp_word});

        // Pause: eight bytes, one event
        t0 = tog_cnt;
        for (int i = 0; i < 7; i++) send_byte(pause_seq[i], 1'b0);
        sample_point();
        check("pause_7_busy", 65'(busy), 65'h1);
        send_byte(pause_seq[7], 1'b0);
        sample_point();
        exp_tog = ~exp_tog; exp_word = 64'hE11477E1F014F077;
        check("pause_key", ps2_key, {exp_tog, exp_word});
        check("pause_toggles", 65'(tog_cnt - t0), 65'd1);

        // Device reply is dropped
        t0 = tog_cnt;
        send_byte(8'hAA, 1'b0);
        sample_point();
        check("aa_toggles", 65'(tog_cnt - t0), 65'd0);
        check("aa_key_held", ps2_key, {exp_tog, exp_word});
        check("aa_busy", 65'(busy), 65'h0);

        // Orphan prefix discarded by inactivity timeout
        t0 = tog_cnt; e0 = err_cnt;
        send_byte(8'hE0, 1'b0);
        #500000;
        sample_point();
        check("tmo_busy", 65'(busy), 65'h0);
        check("tmo_toggles", 65'(tog_cnt - t0), 65'd0);
        check("tmo_ferr", 65'(err_cnt - e0), 65'd0);
        send_byte(8'h1C, 1'b0);
        sample_point();
        exp_tog = ~exp_tog; exp_word = 64'h1C;
        check("tmo_next_key", ps2_key, {exp_tog, exp_word});

        // Parity bit flipped
        send_byte(8'hF0, 1'b0);
        send_byte(8'h2A, 1'b0);
        sample_point();
        exp_tog = ~exp_tog; exp_word = 64'hF02A;
        check("pre_par_key", ps2_key, {exp_tog, exp_word});
        t0 = tog_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b1);
        sample_point();
`ifdef PS2_KEY_PARITY_EN
        check("par_ferr", 65'(err_cnt - e0), 65'd1);
        check("par_toggles", 65'(tog_cnt - t0), 65'd0);
        check("par_key_held", ps2_key, {exp_tog, exp_word});
`else
        exp_tog = ~exp_tog; exp_word = 64'h1C;
        check("par_ferr", 65'(err_cnt - e0), 65'd0);
        check("par_toggles", 65'(tog_cnt - t0), 65'd1);
        check("par_key", ps2_key, {exp_tog, exp_word});
`endif

        // Reset during data bit 4
        send_byte(8'hE0, 1'b0);
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
        sample_point();
        check("mid_frame_busy", 65'(busy), 65'h1);
        reset = 1'b1;
        sample_point();
        check("mid_rst_key", ps2_key, 65'h0);
        check("mid_rst_busy", 65'(busy), 65'h0);
        reset = 1'b0;
        ps2_data_in = 1'b1;
        exp_tog = 1'b0;
        #20000;
        t0 = tog_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b0);
        sample_point();
        exp_tog = ~exp_tog; exp_word = 64'h1C;
        check("post_rst_key", ps2_key, {exp_tog, exp_word});
        check("post_rst_ferr", 65'(err_cnt - e0), 65'd0);
        check("post_rst_busy", 65'(busy), 65'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
